// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between core
// writeback, a small FIFO of returning load data and a debug write port. It also
// keeps a per-register "load outstanding" scoreboard and raises a RAW/WAW hazard.
//
// Handshakes: the load return moves one entry on every cycle where
// ld_valid && ld_ready. A debug write completes in the cycle dbg_ack is high, and
// the requester keeps dbg_req and its data stable until that cycle. Core
// writeback has no handshake; the core keeps core_we low while core_stall is high.
module regfile_wb_arbiter #(
    parameter int LD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_we,
    input  logic [4:0]  core_rd_addr,
    input  logic [31:0] core_wdata,
    input  logic [4:0]  core_rs1_addr,
    input  logic        core_rs1_use,
    input  logic [4:0]  core_rs2_addr,
    input  logic        core_rs2_use,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_addr,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ready,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic        hazard,
    output logic        core_stall,
    output logic        rf_we,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_wdata
);

    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    // One extra pointer bit separates full from empty when the index bits match.
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]    fifo_addr_q [LD_DEPTH];
    logic [4:0]    fifo_addr_d [LD_DEPTH];
    logic [31:0]   fifo_data_q [LD_DEPTH];
    logic [31:0]   fifo_data_d [LD_DEPTH];
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;
    logic          stall_now;
    logic          core_grant;
    logic          fifo_grant;
    logic          dbg_grant;
    logic [4:0]    win_addr;
    logic [31:0]   win_data;
    logic          push;
    logic          pop;

    // FIFO status and head entry, straight from the registered pointers.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        head_addr  = fifo_addr_q[rd_ptr_q[PW-1:0]];
        head_data  = fifo_data_q[rd_ptr_q[PW-1:0]];
    end

    // Write-port arbitration: core, then FIFO head, then debug; a starved FIFO
    // overrides the core for one cycle. Writes to x0 are consumed but not issued.
    always_comb begin
        stall_now  = !fifo_empty && (starve_q == STARVE_LIM);
        core_grant = core_we && !stall_now;
        fifo_grant = !core_grant && !fifo_empty;
        dbg_grant  = !core_grant && fifo_empty && dbg_req;

        win_addr = 5'd0;
        win_data = 32'd0;
        if (core_grant) begin
            win_addr = core_rd_addr;
            win_data = core_wdata;
        end else if (fifo_grant) begin
            win_addr = head_addr;
            win_data = head_data;
        end else if (dbg_grant) begin
            win_addr = dbg_addr;
            win_data = dbg_wdata;
        end

        rf_we      = !rst && (core_grant || fifo_grant || dbg_grant) && (win_addr != 5'd0);
        rf_rd_addr = win_addr;
        rf_wdata   = win_data;
        dbg_ack    = !rst && dbg_grant;
        core_stall = !rst && stall_now;
        ld_ready   = !rst && !fifo_full;

        push = ld_valid && ld_ready;
        pop  = !rst && fifo_grant;

        hazard = !rst && ((core_rs1_use && pending_q[core_rs1_addr]) ||
                          (core_rs2_use && pending_q[core_rs2_addr]) ||
                          (core_we      && pending_q[core_rd_addr])  ||
                          (ld_issue     && pending_q[ld_issue_addr]));
    end

    // Next state for FIFO storage, pointers, starvation counter and scoreboard.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        starve_d    = starve_q;
        pending_d   = pending_q;

        if (push) begin
            fifo_addr_d[wr_ptr_q[PW-1:0]] = ld_rd_addr;
            fifo_data_d[wr_ptr_q[PW-1:0]] = ld_wdata;
            wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end

        // Counts cycles a non-empty FIFO loses to the core; any pop restarts it.
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (core_we && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
        end

        // Clear first so a same-cycle issue to the same register re-sets the bit.
        if (pop && (head_addr != 5'd0)) begin
            pending_d[head_addr] = 1'b0;
        end
        if (ld_issue && (ld_issue_addr != 5'd0)) begin
            pending_d[ld_issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with asynchronous reset; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            starve_q  <= '0;
            pending_q <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                fifo_addr_q[i] <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            starve_q    <= starve_d;
            pending_q   <= pending_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change on the falling edge and
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        core_we;
    logic [4:0]  core_rd_addr;
    logic [31:0] core_wdata;
    logic [4:0]  core_rs1_addr;
    logic        core_rs1_use;
    logic [4:0]  core_rs2_addr;
    logic        core_rs2_use;
    logic        ld_issue;
    logic [4:0]  ld_issue_addr;
    logic        ld_valid;
    logic [4:0]  ld_rd_addr;
    logic [31:0] ld_wdata;
    logic        ld_ready;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic        hazard;
    logic        core_stall;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wdata;

    int total_cnt;
    int bad_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    regfile_wb_arbiter #(.LD_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .core_we       (core_we),
        .core_rd_addr  (core_rd_addr),
        .core_wdata    (core_wdata),
        .core_rs1_addr (core_rs1_addr),
        .core_rs1_use  (core_rs1_use),
        .core_rs2_addr (core_rs2_addr),
        .core_rs2_use  (core_rs2_use),
        .ld_issue      (ld_issue),
        .ld_issue_addr (ld_issue_addr),
        .ld_valid      (ld_valid),
        .ld_rd_addr    (ld_rd_addr),
        .ld_wdata      (ld_wdata),
        .ld_ready      (ld_ready),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_ack       (dbg_ack),
        .hazard        (hazard),
        .core_stall    (core_stall),
        .rf_we         (rf_we),
        .rf_rd_addr    (rf_rd_addr),
        .rf_wdata      (rf_wdata)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        core_we       = 1'b0;
        core_rd_addr  = 5'd0;
        core_wdata    = 32'd0;
        core_rs1_addr = 5'd0;
        core_rs1_use  = 1'b0;
        core_rs2_addr = 5'd0;
        core_rs2_use  = 1'b0;
        ld_issue      = 1'b0;
        ld_issue_addr = 5'd0;
        ld_valid      = 1'b0;
        ld_rd_addr    = 5'd0;
        ld_wdata      = 32'd0;
        dbg_req       = 1'b0;
        dbg_addr      = 5'd0;
        dbg_wdata     = 32'd0;
    endtask

    // Start a new cycle: wait for the falling edge and return inputs to idle.
    task automatic cyc();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_core(input logic [4:0] a, input logic [31:0] d);
        core_we      = 1'b1;
        core_rd_addr = a;
        core_wdata   = d;
    endtask

    task automatic drive_ld(input logic [4:0] a, input logic [31:0] d);
        ld_valid   = 1'b1;
        ld_rd_addr = a;
        ld_wdata   = d;
    endtask

    task automatic drive_dbg(input logic [4:0] a, input logic [31:0] d);
        dbg_req   = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b1;
        idle_inputs();

        // Reset state, with a core write attempted while in reset.
        drive_core(5'd2, 32'h1);
        settle();
        check("por_rf_we", {31'd0, rf_we}, 32'd0);
        check("por_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("por_hazard", {31'd0, hazard}, 32'd0);
        cyc();
        rst = 1'b0;

        // Reset during traffic: two FIFO entries, pending x5, debug waiting.
        cyc(); drive_core(5'd1, 32'h11); drive_ld(5'd10, 32'hA); ld_issue = 1'b1; ld_issue_addr = 5'd5;
        settle();
        check("rst_core_addr", {27'd0, rf_rd_addr}, 32'd1);
        cyc(); drive_core(5'd1, 32'h11); drive_ld(5'd11, 32'hB);
        settle();
        check("rst_ready_one", {31'd0, ld_ready}, 32'd1);
        cyc(); drive_core(5'd1, 32'h11); drive_dbg(5'd6, 32'h66);
        core_rs1_addr = 5'd5; core_rs1_use = 1'b1;
        settle();
        check("rst_pre_hazard", {31'd0, hazard}, 32'd1);
        check("rst_pre_full", {31'd0, ld_ready}, 32'd0);
        #1;
        rst = 1'b1;
        ld_valid = 1'b1;
        #1;
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        cyc(); rst = 1'b0; core_rs1_addr = 5'd5; core_rs1_use = 1'b1;
        settle();
        check("rel_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rel_hazard", {31'd0, hazard}, 32'd0);
        check("rel_rf_we", {31'd0, rf_we}, 32'd0);

        // Load round trip on x7.
        cyc(); ld_issue = 1'b1; ld_issue_addr = 5'd7;
        settle();
        check("rt_issue_hazard", {31'd0, hazard}, 32'd0);
        cyc(); core_rs1_addr = 5'd7; core_rs1_use = 1'b1;
        settle();
        check("rt_raw_hazard", {31'd0, hazard}, 32'd1);
        cyc(); core_rs1_addr = 5'd7; core_rs1_use = 1'b1; drive_ld(5'd7, 32'hDEADBEEF);
        settle();
        check("rt_push_hazard", {31'd0, hazard}, 32'd1);
        check("rt_push_we", {31'd0, rf_we}, 32'd0);
        cyc(); core_rs1_addr = 5'd7; core_rs1_use = 1'b1;
        settle();
        check("rt_wr_we", {31'd0, rf_we}, 32'd1);
        check("rt_wr_addr", {27'd0, rf_rd_addr}, 32'd7);
        check("rt_wr_data", rf_wdata, 32'hDEADBEEF);
        check("rt_wr_hazard", {31'd0, hazard}, 32'd1);
        cyc(); core_rs1_addr = 5'd7; core_rs1_use = 1'b1;
        settle();
        check("rt_clear_hazard", {31'd0, hazard}, 32'd0);

        // Full FIFO under a continuously writing core, then starvation release.
        cyc(); drive_core(5'd1, 32'h11); drive_ld(5'd12, 32'h100);
        settle();
        check("full_c1_ready", {31'd0, ld_ready}, 32'd1);
        cyc(); drive_core(5'd1, 32'h11); drive_ld(5'd13, 32'h101);
        settle();
        check("full_c2_ready", {31'd0, ld_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(); drive_core(5'd1, 32'h11);
            settle();
            check("full_ready", {31'd0, ld_ready}, 32'd0);
            check("full_no_stall", {31'd0, core_stall}, 32'd0);
            check("full_core_addr", {27'd0, rf_rd_addr}, 32'd1);
        end
        cyc();
        settle();
        check("starve_stall", {31'd0, core_stall}, 32'd1);
        check("starve_we", {31'd0, rf_we}, 32'd1);
        check("starve_addr", {27'd0, rf_rd_addr}, 32'd12);
        check("starve_data", rf_wdata, 32'h100);
        cyc(); drive_core(5'd1, 32'h22);
        settle();
        check("after_stall", {31'd0, core_stall}, 32'd0);
        check("after_ready", {31'd0, ld_ready}, 32'd1);
        check("after_core_data", rf_wdata, 32'h22);
        cyc();
        settle();
        check("drain_addr", {27'd0, rf_rd_addr}, 32'd13);
        check("drain_data", rf_wdata, 32'h101);

        // Ten back-to-back push/pop cycles across the pointer wrap.
        cyc(); drive_ld(5'd20, 32'hA000);
        settle();
        check("wrap_first_we", {31'd0, rf_we}, 32'd0);
        exp_q.push_back(32'hA000);
        for (int k = 1; k < 10; k++) begin
            cyc(); drive_ld(5'(20 + k), 32'hA000 + 32'(k));
            settle();
            check("wrap_ready", {31'd0, ld_ready}, 32'd1);
            check("wrap_we", {31'd0, rf_we}, 32'd1);
            exp_v = exp_q.pop_front();
            check("wrap_data", rf_wdata, exp_v);
            exp_q.push_back(32'hA000 + 32'(k));
        end
        cyc();
        settle();
        check("wrap_last_we", {31'd0, rf_we}, 32'd1);
        exp_v = exp_q.pop_front();
        check("wrap_last_data", rf_wdata, exp_v);
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // Priority: core, then FIFO head, then debug.
        cyc(); drive_ld(5'd4, 32'd2);
        settle();
        check("pri_setup_we", {31'd0, rf_we}, 32'd0);
        cyc(); drive_core(5'd3, 32'd1); drive_dbg(5'd6, 32'd3);
        settle();
        check("pri_c1_addr", {27'd0, rf_rd_addr}, 32'd3);
        check("pri_c1_data", rf_wdata, 32'd1);
        check("pri_c1_ack", {31'd0, dbg_ack}, 32'd0);
        cyc(); drive_dbg(5'd6, 32'd3);
        settle();
        check("pri_c2_addr", {27'd0, rf_rd_addr}, 32'd4);
        check("pri_c2_data", rf_wdata, 32'd2);
        check("pri_c2_ack", {31'd0, dbg_ack}, 32'd0);
        cyc(); drive_dbg(5'd6, 32'd3);
        settle();
        check("pri_c3_we", {31'd0, rf_we}, 32'd1);
        check("pri_c3_addr", {27'd0, rf_rd_addr}, 32'd6);
        check("pri_c3_data", rf_wdata, 32'd3);
        check("pri_c3_ack", {31'd0, dbg_ack}, 32'd1);
        cyc();
        settle();
        check("pri_c4_ack", {31'd0, dbg_ack}, 32'd0);
        check("pri_c4_we", {31'd0, rf_we}, 32'd0);

        // x0 handling for load return, debug and load issue.
        cyc(); drive_ld(5'd0, 32'h55);
        settle();
        cyc();
        settle();
        check("x0_ld_we", {31'd0, rf_we}, 32'd0);
        cyc(); drive_dbg(5'd0, 32'h77);
        settle();
        check("x0_dbg_ack", {31'd0, dbg_ack}, 32'd1);
        check("x0_dbg_we", {31'd0, rf_we}, 32'd0);
        cyc(); ld_issue = 1'b1; ld_issue_addr = 5'd0; core_rs1_addr = 5'd0; core_rs1_use = 1'b1;
        settle();
        check("x0_issue_hazard", {31'd0, hazard}, 32'd0);
        cyc(); core_rs1_addr = 5'd0; core_rs1_use = 1'b1; drive_core(5'd0, 32'h1);
        settle();
        check("x0_after_hazard", {31'd0, hazard}, 32'd0);
        check("x0_core_we", {31'd0, rf_we}, 32'd0);

        // Set and clear of pending[9] in the same cycle.
        cyc(); ld_issue = 1'b1; ld_issue_addr = 5'd9;
        settle();
        cyc(); drive_ld(5'd9, 32'h99);
        settle();
        cyc(); ld_issue = 1'b1; ld_issue_addr = 5'd9;
        settle();
        check("col_we", {31'd0, rf_we}, 32'd1);
        check("col_addr", {27'd0, rf_rd_addr}, 32'd9);
        cyc(); drive_core(5'd9, 32'h0);
        settle();
        check("col_waw_hazard", {31'd0, hazard}, 32'd1);
        cyc(); core_rs2_addr = 5'd9; core_rs2_use = 1'b1;
        settle();
        check("col_rs2_hazard", {31'd0, hazard}, 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
